// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with status/control register and interrupt.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_new,
  output logic        rx_ack,
  input  logic        sel_data,
  input  logic        sel_stat,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        irq
);

  localparam int L     = DEPTH_LOG2;
  localparam int DEPTH = 1 << L;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [L:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [L:0]  thresh_q, thresh_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic [7:0]  mem_q [DEPTH];

  logic [L:0]  count;
  logic        empty, full;
  logic        sample, push, drop, pop, stat_wr;
  logic [7:0]  head;
  logic [7:0]  count8;
  logic        unused_bits;

  assign count   = wptr_q - rptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (L+1)'(DEPTH));
  assign count8  = 8'(count);
  assign head    = empty ? 8'h00 : mem_q[rptr_q[L-1:0]];

  // Full/empty decisions use the pre-update count, so a same-cycle pop never
  // rescues a byte arriving into a full FIFO, and never pops an empty one.
  assign sample  = (state_q == S_IDLE) && rx_new;
  assign push    = sample && !full;
  assign drop    = sample && full;
  assign pop     = bus_read && sel_data && !empty;
  assign stat_wr = bus_write && sel_stat;

  assign unused_bits = ^bus_in[13:L+1];

  always_comb begin
    state_d = state_q;
    rx_ack  = 1'b0;
    unique case (state_q)
      S_IDLE: if (rx_new) state_d = S_ACK;
      S_ACK: begin
        rx_ack  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (!rx_new) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    thresh_d = thresh_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (stat_wr) begin
      irq_en_d = bus_in[14];
      thresh_d = bus_in[L:0];
      if (bus_in[15]) ovf_d = 1'b0;
    end
    if (drop) ovf_d = 1'b1;
    irq_d = irq_en_q & (ovf_q | ((thresh_q != '0) && (count >= thresh_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      thresh_q <= (L+1)'(1);
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      thresh_q <= thresh_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[L-1:0]] <= rx_data;
  end

  always_comb begin
    bus_out = 16'h0000;
    if (sel_data)      bus_out = {~empty, 7'b0, head};
    else if (sel_stat) bus_out = {ovf_q, irq_en_q, 6'b0, count8};
  end

  assign irq = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Memory-mapped receive buffer between the UART receiver and the CPU data bus address decode.
- Drains the UART's single-byte holding register into a DEPTH-entry FIFO via a level handshake, so bursts from the host are not lost while the CPU is stalled on SDRAM.
- Exposes a data register and a status/control register to the bus decode.
- Raises an interrupt request at a programmable fill threshold or on overflow.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2^DEPTH_LOG2, legal range 2..7.

Ports:
- clk  in  1  CPU clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from UART; valid while rx_new = 1.
- rx_new  in  1  level; UART holds a byte.
- rx_ack  out  1  one-cycle pulse; byte consumed, UART clears rx_new.
- sel_data  in  1  decode select, data register.
- sel_stat  in  1  decode select, status/control register; never asserted together with sel_data.
- bus_read  in  1  one-cycle pulse at completion of a CPU read of the selected register.
- bus_write  in  1  one-cycle write strobe to the selected register.
- bus_in  in  16  write data.
- bus_out  out  16  read data, combinational from select and state.
- irq  out  1  registered interrupt request.

Behaviour:
- Storage:
  - DEPTH x 8 array.
  - wptr and rptr are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - count = wptr - rptr.
  - empty when count = 0; full when count = DEPTH.
- Reset values:
  - Pointers 0, ovf 0, irq_en 0, thresh 1.
  - FSM in IDLE; rx_ack 0; irq 0.
  - Array contents are don't-care.
- Ingress FSM:
  - IDLE: if rx_new = 1 and not full, write rx_data at wptr and increment wptr. If full, drop the byte and set ovf = 1. In both cases go to ACK.
  - ACK: rx_ack = 1 for exactly this cycle; go to WAIT.
  - WAIT: stay until rx_new = 0, then go to IDLE.
  - Pushed byte is visible in count and bus_out on the cycle after the IDLE sample.
  - Minimum byte-to-byte spacing is 3 cycles.
- Read decode:
  - sel_data: bus_out = {~empty, 7'b0, head}. head = array[rptr]; head = 0 when empty.
  - sel_stat: bus_out = {ovf, irq_en, 6'b0, count zero-extended to 8}.
  - Neither select: bus_out = 0.
- Pop:
  - bus_read & sel_data & ~empty increments rptr.
  - bus_read on an empty FIFO has no effect.
  - A read of sel_stat has no side effects.
- Write:
  - bus_write & sel_stat: irq_en <= bus_in[14]; thresh <= bus_in[DEPTH_LOG2:0]; if bus_in[15] = 1, clear ovf (write-1-to-clear).
  - Writes to sel_data are ignored.
- Simultaneous events:
  - Push and pop in the same cycle both occur; count is unchanged.
  - The full check uses pre-pop count: when full, the pushed byte is dropped and ovf is set even if a pop happens that cycle.
  - Empty plus same-cycle push and pop: the pop is ignored and the byte is stored.
  - An ovf set and a W1C clear in the same cycle leave ovf = 1.
- Interrupt:
  - irq <= irq_en & (ovf | (thresh != 0 & count >= thresh)).
  - Evaluated on the registered state, so irq lags the triggering state by one cycle.
  - thresh = 0 disables the level condition only.
- Reset mid-handshake:
  - FSM returns to IDLE.
  - If the UART still holds rx_new = 1 after reset, that byte is captured again; this is intended behaviour.

Test Plan:
- Single byte: after reset, rx_new = 1 with rx_data = 0x41.
  - rx_ack pulses on cycle 2.
  - Read stat = 0x0001; read data = 0x8041; subsequent stat = 0x0000; data = 0x0000.
- Fill and overflow, DEPTH_LOG2 = 4: push 17 bytes 0x00..0x10.
  - stat = 0x8010, with ovf set and 0x10 dropped.
  - 16 data reads return 0x8000..0x800F in order.
  - Write stat 0x8000 to clear ovf; stat then reads 0x0000.
- Wrap-around: 40 push/pop pairs interleaved.
  - Data order preserved across pointer wrap.
  - count never exceeds 1.
- Simultaneous push and pop:
  - count = 3 with push and pop in the same cycle → count stays 3, head advances.
  - count = 16 with push and pop in the same cycle → count 15, ovf = 1.
- Interrupt: write stat 0x4004.
  - irq low at count 3; irq high one cycle after count reaches 4.
  - Pops to count 3 drop irq the next cycle.
  - Write 0x0004 masks irq.
- Reset during WAIT while rx_new is held high:
  - FSM restarts and the byte is recaptured.
  - count = 1 and rx_ack pulses again.
